// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding constants and FSM state type for the instruction encoder/decoder pair.
package inst_encoder_pkg;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FULL
  } enc_state_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Field-input handshake and instruction-memory write port of the encoder.
interface inst_encoder_if #(
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic          fmt;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic [3:0]    alu_ctrl;
  logic          w_en;
  logic [31:0]   imm;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;

  modport master (
    output in_valid, fmt, rs1, rs2, rd, alu_ctrl, w_en, imm, mem_ack,
    input  in_ready, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, fmt, rs1, rs2, rd, alu_ctrl, w_en, imm, mem_ack,
    output in_ready, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/inst_enc_comb.sv
// Combinational field-set to RV32I word encoder; illegal field sets encode as NOP.
module inst_enc_comb
  import inst_encoder_pkg::*;
(
  input  logic        fmt,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [3:0]  alu_ctrl,
  input  logic        w_en,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd_eff;
  logic        is_shift;
  logic [31:0] raw;

  assign funct3   = alu_ctrl[2:0];
  assign alt      = alu_ctrl[3];
  assign rd_eff   = w_en ? rd : '0;
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    if (!fmt) begin
      raw     = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd_eff, OPC_OP};
      illegal = alt && !((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA));
    end else if (is_shift) begin
      raw     = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd_eff, OPC_OP_IMM};
      illegal = (imm > 32'd31) || (alt && (funct3 != F3_SRL_SRA));
    end else begin
      // imm[31:11] must be a pure sign extension to fit the 12-bit field
      raw     = {imm[11:0], rs1, funct3, rd_eff, OPC_OP_IMM};
      illegal = !((&imm[31:11]) || !(|imm[31:11])) || alt;
    end
    word = illegal ? NOP_WORD : raw;
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field sets, encodes them and fills instruction memory sequentially.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  inst_encoder_if.slave bus,
  input  logic          clear,
  output logic          full,
  output logic          err
);

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

  enc_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [31:0]   enc_word;
  logic          enc_illegal;

  inst_enc_comb u_enc (
    .fmt      (bus.fmt),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rd       (bus.rd),
    .alu_ctrl (bus.alu_ctrl),
    .w_en     (bus.w_en),
    .imm      (bus.imm),
    .word     (enc_word),
    .illegal  (enc_illegal)
  );

  assign bus.in_ready  = (state_q == IDLE) && !clear && !rst;
  assign bus.mem_wr    = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign full          = (state_q == FULL);
  assign err           = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (clear) begin
      state_d = IDLE;
      addr_d  = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            wdata_d = enc_word;
            err_d   = err_q | enc_illegal;
            state_d = WRITE;
          end
        end
        WRITE: begin
          // The last address is held rather than wrapped; only clear returns to 0.
          if (bus.mem_ack) begin
            if (addr_q == LAST) begin
              state_d = FULL;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = IDLE;
            end
          end
        end
        FULL: ;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder against a behavioural encoding model.
module tb_inst_encoder;

  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;
  logic clear;
  logic full;
  logic err;

  inst_encoder_if #(.DEPTH(DEPTH)) bus ();

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .clear (clear),
    .full  (full),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        chk_en = 1'b0;
  logic        exp_wr, exp_full, exp_err, exp_rdy;
  int unsigned exp_addr;
  logic [31:0] exp_word;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference encoding built from the RV32I field layout with plain arithmetic.
  function automatic void model(input logic f, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] d, input logic [3:0] ac, input logic we,
                                input logic [31:0] im, output logic [31:0] w, output logic ill);
    int unsigned f3;
    int unsigned dst;
    int signed   simm;
    logic [31:0] f7;
    f3   = int'(ac[2:0]);
    dst  = we ? int'(d) : 0;
    simm = $signed(im);
    f7   = ac[3] ? 32'h4000_0000 : 32'h0;
    if (!f) begin
      ill = ac[3] && !(f3 == 0 || f3 == 5);
      w = f7 | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12) | (32'(dst) << 7) | 32'h33;
    end else if (f3 == 1 || f3 == 5) begin
      ill = (im > 32'd31) || (ac[3] && f3 != 5);
      w = f7 | (im << 20) | (32'(r1) << 15) | (32'(f3) << 12) | (32'(dst) << 7) | 32'h13;
    end else begin
      ill = (simm < -2048) || (simm > 2047) || ac[3];
      w = (im << 20) | (32'(r1) << 15) | (32'(f3) << 12) | (32'(dst) << 7) | 32'h13;
    end
    if (ill) w = 32'h0000_0013;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_wr", 32'(bus.mem_wr), 32'(exp_wr));
      if (exp_wr) begin
        check("mem_addr", 32'(bus.mem_addr), exp_addr);
        check("mem_wdata", bus.mem_wdata, exp_word);
      end
      check("full", 32'(full), 32'(exp_full));
      check("err", 32'(err), 32'(exp_err));
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    bus.fmt      = 1'($urandom);
    bus.rs1      = 5'($urandom);
    bus.rs2      = 5'($urandom);
    bus.rd       = 5'($urandom);
    bus.alu_ctrl = 4'($urandom);
    bus.w_en     = 1'($urandom);
    bus.imm      = $urandom;
  endtask

  task automatic do_clear(input logic with_valid);
    clear   = 1'b1;
    exp_rdy = 1'b0;
    if (with_valid) begin
      rand_fields();
      bus.in_valid = 1'b1;
    end
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    exp_wr       = 1'b0;
    exp_addr     = 0;
    exp_err      = 1'b0;
    exp_full     = 1'b0;
    exp_rdy      = 1'b1;
  endtask

  // abort: 0 = normal ack, 1 = clear during hold, 2 = async reset during hold
  task automatic write_word(input logic f, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] d, input logic [3:0] ac, input logic we,
                            input logic [31:0] im, input int unsigned wait_n, input int unsigned abort,
                            input logic use_lit, input logic [31:0] lit, input int unsigned lit_addr);
    logic [31:0] w;
    logic        ill;
    if (exp_full) return;
    bus.fmt = f; bus.rs1 = r1; bus.rs2 = r2; bus.rd = d;
    bus.alu_ctrl = ac; bus.w_en = we; bus.imm = im;
    bus.in_valid = 1'b1;
    bus.mem_ack  = 1'($urandom);
    tick();
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    model(f, r1, r2, d, ac, we, im, w, ill);
    exp_word = w;
    exp_err  = exp_err | ill;
    exp_wr   = 1'b1;
    exp_rdy  = 1'b0;
    if (use_lit) begin
      check("lit_wdata", bus.mem_wdata, lit);
      check("lit_addr", 32'(bus.mem_addr), lit_addr);
      check("lit_wr_latency", 32'(bus.mem_wr), 32'd1);
    end
    for (int unsigned i = 0; i < wait_n; i++) begin
      rand_fields();
      bus.in_valid = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    if (abort == 1) begin
      bus.mem_ack = 1'($urandom);
      do_clear(1'b0);
      bus.mem_ack = 1'b0;
      return;
    end
    if (abort == 2) begin
      #2 rst = 1'b1;
      #1;
      check("rst_mem_wr_async", 32'(bus.mem_wr), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      exp_wr = 1'b0; exp_addr = 0; exp_err = 1'b0; exp_full = 1'b0; exp_rdy = 1'b0;
      tick();
      rst     = 1'b0;
      exp_rdy = 1'b1;
      return;
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    exp_wr = 1'b0;
    if (exp_addr == DEPTH - 1) begin
      exp_full = 1'b1;
      exp_rdy  = 1'b0;
    end else begin
      exp_addr++;
      exp_rdy = 1'b1;
    end
  endtask

  task automatic rand_write(input int unsigned wait_n, input int unsigned abort);
    logic [31:0] im;
    logic [31:0] edges [4];
    int signed   s;
    edges[0] = 32'h0000_07FF; edges[1] = 32'h0000_0800;
    edges[2] = 32'hFFFF_F800; edges[3] = 32'hFFFF_F7FF;
    case ($urandom % 4)
      0: begin s = int'($urandom_range(0, 4095)) - 2048; im = s; end
      1: im = $urandom_range(0, 40);
      2: im = $urandom;
      default: im = edges[$urandom % 4];
    endcase
    write_word(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               {($urandom % 4) == 0, 3'($urandom)}, 1'($urandom), im,
               wait_n, abort, 1'b0, 32'h0, 0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.mem_ack = 1'b0;
    bus.fmt = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
    bus.alu_ctrl = '0; bus.w_en = 1'b0; bus.imm = '0;
    exp_wr = 1'b0; exp_addr = 0; exp_word = '0;
    exp_full = 1'b0; exp_err = 1'b0; exp_rdy = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    check("reset_mem_wdata", bus.mem_wdata, 32'h0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0; exp_rdy = 1'b1;
    tick();

    write_word(1'b0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 32'h0, 1, 0, 1'b1, 32'h002081B3, 0);
    do_clear(1'b1);
    write_word(1'b0, 5'd6, 5'd7, 5'd5, 4'b1000, 1'b1, 32'h0, 0, 0, 1'b1, 32'h407302B3, 0);
    write_word(1'b1, 5'd0, 5'd0, 5'd1, 4'b0000, 1'b1, 32'hFFFF_FFFF, 2, 0, 1'b1, 32'hFFF00093, 1);
    write_word(1'b1, 5'd4, 5'd0, 5'd4, 4'b1101, 1'b1, 32'd3, 0, 0, 1'b1, 32'h40325213, 2);
    write_word(1'b0, 5'd1, 5'd2, 5'd9, 4'b0000, 1'b0, 32'h0, 0, 0, 1'b1, 32'h00208033, 3);
    write_word(1'b1, 5'd2, 5'd0, 5'd2, 4'b0000, 1'b1, 32'h0000_0800, 0, 0, 1'b1, 32'h00000013, 4);
    check("err_after_illegal", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++)
      write_word(1'b0, 5'(i), 5'(i + 1), 5'(i + 2), 4'b0111, 1'b1, 32'h0, 1, 0, 1'b0, 32'h0, 0);
    check("err_sticky", 32'(err), 32'd1);
    do_clear(1'b0);
    check("err_cleared", 32'(err), 32'd0);

    write_word(1'b0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 32'h0, 5, 0, 1'b1, 32'h002081B3, 0);
    write_word(1'b1, 5'd3, 5'd0, 5'd3, 4'b0000, 1'b1, 32'd7, 3, 2, 1'b0, 32'h0, 0);
    write_word(1'b1, 5'd3, 5'd0, 5'd3, 4'b0000, 1'b1, 32'd7, 0, 0, 1'b1, 32'h00718193, 0);
    write_word(1'b0, 5'd1, 5'd1, 5'd1, 4'b0000, 1'b1, 32'h0, 2, 1, 1'b0, 32'h0, 0);

    for (int n = 0; n < 80; n++) begin
      if (exp_full || ($urandom % 12) == 0) do_clear(1'($urandom));
      rand_write($urandom % 4, ($urandom % 20 == 0) ? 1 : (($urandom % 20 == 0) ? 2 : 0));
      if ($urandom % 3 == 0) begin
        bus.mem_ack = 1'($urandom);
        tick();
        bus.mem_ack = 1'b0;
      end
    end

    do_clear(1'b0);
    for (int unsigned i = 0; i < DEPTH; i++) rand_write($urandom % 2, 0);
    check("full_after_last_ack", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      bus.in_valid = 1'b1;
      bus.mem_ack  = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    check("full_held", 32'(full), 32'd1);
    do_clear(1'b0);
    check("full_cleared", 32'(full), 32'd0);
    write_word(1'b0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 32'h0, 0, 0, 1'b1, 32'h002081B3, 0);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
